multi_issue_decode_stage: RTL and testbench
===========================================

Name: multi_issue_decode_stage

Overview:
- Parametrised, registered successor of the single-instruction decode stage.
- Decodes up to LANES fetch-buffer instructions per cycle, one integer_decoder per lane, and registers the decoded packets into a one-deep output stage with a stall handshake.
- Sequential control added over the single-lane stage: group truncation on fence, branch or exception; a fence-serialisation FSM; an exception-hold FSM; and a consumed-count report back to the fetch buffer.
- Sits between the fetch buffer and issue/rename.

Parameters:
- LANES, 2, instructions decoded per cycle (1..4).
- CNT_W, $clog2(LANES+1), width of the consumed count.

Ports:
- clk_i  in  1  core clock
- rst_n_i  in  1  asynchronous active-low reset
- valid_i  in  LANES  lane-valid mask from fetch buffer; contiguous from lane 0
- instr_i  in  LANES*32  instruction per lane
- instr_address_i  in  LANES*32  PC per lane
- compressed_i  in  LANES  compressed flag per lane
- priv_level_i  in  1  privilege level, shared
- stall_i  in  1  downstream cannot accept the output packet
- flush_i  in  1  pipeline flush / redirect
- pipeline_empty_i  in  1  execution pipeline drained
- ready_o  out  1  stage accepts a group this cycle
- consumed_o  out  CNT_W  lanes taken from fetch buffer this cycle
- valid_o  out  LANES  registered lane valid
- instr_address_o  out  LANES*32  registered PC
- compressed_o  out  LANES  registered compressed flag
- immediate_o  out  LANES*2*32  registered immediates
- imm_valid_o  out  LANES*2  registered immediate valids
- reg_src_o  out  LANES*2*5  registered sources
- reg_dest_o  out  LANES*5  registered destination
- branch_o, link_o, memory_o, fence_o  out  LANES each  registered flags
- address_operand_o  out  LANES*2  registered address-operand select
- exu_valid_o  out  LANES*exu_valid_t  registered unit valids
- exu_uop_o  out  LANES*exu_uop_t  registered micro-ops
- exception_generated_o  out  LANES  registered exception flag
- exception_vector_o  out  LANES*5  registered exception vector

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - all output registers 0, so valid_o=0 and exception_generated_o=0;
  - FSM in RUN, consumed_o=0.
- ready_o = (state==RUN) & !flush_i & (!stall_i | valid_o==0). Combinational.
- Accept: ready_o & valid_i[0]. Latency is 1 cycle: the decoded group appears on the outputs on the next edge.
- Truncation point t is the lowest valid lane k whose decode gives an exception, fence_o or branch_o.
  - Lanes 0..t are kept and lanes >t are discarded.
  - consumed_o = t+1. With no truncation, consumed_o = popcount(valid_i).
  - Discarded lanes stay in the fetch buffer.
- consumed_o is 0 whenever no accept occurs.
- Per-lane priority: exception outranks fence, which outranks branch. A lane that raises an exception has its exu_valid_o forced to 0.
- Stall: if stall_i and valid_o!=0, all output registers hold and nothing is accepted.
- If valid_o==0, the stage accepts even while stall_i is high (the bubble fills).
- No accept with no stall: valid_o clears to 0 on the next edge.
- FSM:
  - RUN: on accept of a fence lane (no older exception), go to FENCE_WAIT. On accept of an exception lane, go to EXC_HOLD.
  - FENCE_WAIT: ready_o=0. Return to RUN on the first cycle with pipeline_empty_i=1, the output register empty and no stall. ready_o is reasserted the cycle after that.
  - EXC_HOLD: ready_o=0. Leave only on flush_i.
- Flush:
  - flush_i forces state to RUN and clears valid_o to 0 on the next edge.
  - No accept in the flush cycle; consumed_o=0.
  - Flush outranks stall, fence wait and a pending accept.
- Reset mid-operation discards all state immediately, with no partial group.
- LANES=1 degenerates to the single-lane stage plus the output register and the FSM.

Test Plan:
- Reset, then valid_i=2'b11 with lane0=ADDI x1,x0,5 and lane1=ADD x2,x1,x1 -> next cycle valid_o=11, immediate_o[0][0]=5, reg_dest_o={2,1}; consumed_o=2 in the accept cycle.
- Lane0=FENCE, lane1=ADD -> consumed_o=1, valid_o=01, fence_o[0]=1. State goes to FENCE_WAIT with ready_o=0 until pipeline_empty_i=1 is held; ready_o=1 the following cycle; lane1 is then re-presented and accepted.
- Lane0=JAL x1,+8, lane1=ADD -> consumed_o=1, valid_o=01, branch_o[0]=1, link_o[0]=1. State stays RUN.
- Lane0=ADD, lane1=illegal 32'h0 -> valid_o=11, exception_generated_o=10 with the illegal-instruction vector, exu_valid_o[1]=0. State goes to EXC_HOLD and ready_o stays 0 until a 1-cycle flush_i; the next cycle has valid_o=0 and ready_o=1.
- Output holds a valid packet and stall_i=1 for 3 cycles -> outputs bit-stable, ready_o=0, consumed_o=0. stall_i=0 -> the new group loads.
- flush_i with stall_i=1 in FENCE_WAIT -> next cycle valid_o=0, state RUN. Asserting rst_n_i=0 asynchronously mid-stall clears valid_o in the same cycle.

Source files
------------

// File: rtl/multi_issue_decode_stage.sv
// Multi-issue decode stage: decodes up to LANES fetch-buffer instructions per
// cycle, truncates the group at the first exception/fence/branch lane, and
// registers the surviving lanes into a one-deep output stage. A small FSM
// serialises fences (wait for an empty pipeline) and parks on exceptions
// until the pipeline is flushed.
//
// Handshake: the fetch buffer presents a contiguous valid_i mask from lane 0.
// A group is taken when ready_o & valid_i[0]; in that same cycle consumed_o
// tells the fetch buffer how many lanes to pop (0 whenever nothing is taken).
// Downstream signals stall_i when it cannot take the registered packet; an
// empty output register still fills while stall_i is high.
package mids_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FENCE_WAIT = 2'd1,
    EXC_HOLD   = 2'd2
  } decode_state_e;

  typedef struct packed {
    logic alu;
    logic bru;
    logic lsu;
    logic csr;
  } exu_valid_t;

  typedef struct packed {
    logic [2:0] funct3;
    logic       alt;
  } exu_uop_t;

  // One decoded lane; also the layout of each lane of the output register.
  typedef struct packed {
    logic             valid;
    logic [31:0]      addr;
    logic             compressed;
    logic [1:0][31:0] imm;
    logic [1:0]       imm_valid;
    logic [1:0][4:0]  src;
    logic [4:0]       dest;
    logic             branch;
    logic             link;
    logic             memory;
    logic             fence;
    logic [1:0]       addr_op;  // bit0: PC is the base, bit1: immediate offset
    exu_valid_t       exu_valid;
    exu_uop_t         exu_uop;
    logic             exc;
    logic [4:0]       exc_vec;
  } lane_pkt_t;

  localparam logic [4:0] EXC_ILLEGAL = 5'd2;
  localparam logic [4:0] EXC_BREAK   = 5'd3;
  localparam logic [4:0] EXC_ECALL_U = 5'd8;
  localparam logic [4:0] EXC_ECALL_M = 5'd11;

  // RV32I integer decoder for one lane (compressed forms arrive expanded).
  function automatic lane_pkt_t integer_decoder(input logic [31:0] i, input logic [31:0] pc,
                                                input logic comp, input logic priv);
    lane_pkt_t   p;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, ret;
    logic        ill;
    rd    = i[11:7];
    rs1   = i[19:15];
    rs2   = i[24:20];
    f3    = i[14:12];
    f7    = i[31:25];
    imm_i = {{20{i[31]}}, i[31:20]};
    imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
    imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    imm_u = {i[31:12], 12'b0};
    imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    ret   = pc + (comp ? 32'd2 : 32'd4);
    p = '0;
    ill = 1'b0;
    p.valid = 1'b1;
    p.addr = pc;
    p.compressed = comp;
    p.exu_uop.funct3 = f3;
    case (i[6:0])
      7'b0110111: begin  // LUI
        p.dest = rd; p.imm[0] = imm_u; p.imm_valid = 2'b01; p.addr_op = 2'b10; p.exu_valid.alu = 1'b1;
      end
      7'b0010111: begin  // AUIPC
        p.dest = rd; p.imm[0] = imm_u; p.imm_valid = 2'b01; p.addr_op = 2'b11; p.exu_valid.alu = 1'b1;
      end
      7'b1101111: begin  // JAL
        p.dest = rd; p.imm[0] = imm_j; p.imm[1] = ret; p.imm_valid = 2'b11; p.addr_op = 2'b11;
        p.branch = 1'b1; p.link = (rd != 5'd0); p.exu_valid.bru = 1'b1;
      end
      7'b1100111: begin  // JALR
        ill = (f3 != 3'd0);
        p.src[0] = rs1; p.dest = rd; p.imm[0] = imm_i; p.imm[1] = ret; p.imm_valid = 2'b11;
        p.addr_op = 2'b10; p.branch = 1'b1; p.link = (rd != 5'd0); p.exu_valid.bru = 1'b1;
      end
      7'b1100011: begin  // conditional branches
        ill = (f3 == 3'd2) || (f3 == 3'd3);
        p.src[0] = rs1; p.src[1] = rs2; p.imm[0] = imm_b; p.imm_valid = 2'b01;
        p.addr_op = 2'b11; p.branch = 1'b1; p.exu_valid.bru = 1'b1;
      end
      7'b0000011: begin  // loads
        ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        p.src[0] = rs1; p.dest = rd; p.imm[0] = imm_i; p.imm_valid = 2'b01;
        p.addr_op = 2'b10; p.memory = 1'b1; p.exu_valid.lsu = 1'b1;
      end
      7'b0100011: begin  // stores
        ill = (f3 > 3'd2);
        p.src[0] = rs1; p.src[1] = rs2; p.imm[0] = imm_s; p.imm_valid = 2'b01;
        p.addr_op = 2'b10; p.memory = 1'b1; p.exu_valid.lsu = 1'b1;
      end
      7'b0010011: begin  // ALU with immediate
        ill = ((f3 == 3'd1) && (f7 != 7'd0)) ||
              ((f3 == 3'd5) && (f7 != 7'd0) && (f7 != 7'b0100000));
        p.src[0] = rs1; p.dest = rd; p.imm[0] = imm_i; p.imm_valid = 2'b01;
        p.exu_uop.alt = (f3 == 3'd5) && i[30]; p.exu_valid.alu = 1'b1;
      end
      7'b0110011: begin  // ALU register-register
        ill = !((f7 == 7'd0) || ((f7 == 7'b0100000) && ((f3 == 3'd0) || (f3 == 3'd5))));
        p.src[0] = rs1; p.src[1] = rs2; p.dest = rd; p.exu_uop.alt = i[30]; p.exu_valid.alu = 1'b1;
      end
      7'b0001111: begin  // FENCE / FENCE.I
        ill = (f3 > 3'd1);
        p.fence = 1'b1; p.exu_valid.lsu = 1'b1;
      end
      7'b1110011: begin  // SYSTEM
        if (f3 == 3'd0) begin
          if (i[31:20] == 12'h000 && rs1 == 5'd0 && rd == 5'd0) begin
            p.exc = 1'b1; p.exc_vec = priv ? EXC_ECALL_M : EXC_ECALL_U;
          end else if (i[31:20] == 12'h001 && rs1 == 5'd0 && rd == 5'd0) begin
            p.exc = 1'b1; p.exc_vec = EXC_BREAK;
          end else begin
            ill = 1'b1;
          end
        end else if (f3 == 3'd4) begin
          ill = 1'b1;
        end else begin
          p.dest = rd; p.src[0] = f3[2] ? 5'd0 : rs1;
          p.imm[0] = {20'd0, i[31:20]}; p.imm[1] = {27'd0, rs1};
          p.imm_valid = {f3[2], 1'b1}; p.exu_valid.csr = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      p.exc = 1'b1;
      p.exc_vec = EXC_ILLEGAL;
    end
    // An excepting lane never issues and outranks its own fence/branch role.
    if (p.exc) begin
      p.exu_valid = '0;
      p.fence = 1'b0;
      p.branch = 1'b0;
      p.link = 1'b0;
    end
    return p;
  endfunction

endpackage

module multi_issue_decode_stage
  import mids_pkg::*;
#(
  parameter int LANES = 2,
  parameter int CNT_W = $clog2(LANES + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [LANES-1:0]             valid_i,
  input  logic [LANES-1:0][31:0]       instr_i,
  input  logic [LANES-1:0][31:0]       instr_address_i,
  input  logic [LANES-1:0]             compressed_i,
  input  logic                         priv_level_i,
  input  logic                         stall_i,
  input  logic                         flush_i,
  input  logic                         pipeline_empty_i,
  output logic                         ready_o,
  output logic [CNT_W-1:0]             consumed_o,
  output logic [LANES-1:0]             valid_o,
  output logic [LANES-1:0][31:0]       instr_address_o,
  output logic [LANES-1:0]             compressed_o,
  output logic [LANES-1:0][1:0][31:0]  immediate_o,
  output logic [LANES-1:0][1:0]        imm_valid_o,
  output logic [LANES-1:0][1:0][4:0]   reg_src_o,
  output logic [LANES-1:0][4:0]        reg_dest_o,
  output logic [LANES-1:0]             branch_o,
  output logic [LANES-1:0]             link_o,
  output logic [LANES-1:0]             memory_o,
  output logic [LANES-1:0]             fence_o,
  output logic [LANES-1:0][1:0]        address_operand_o,
  output exu_valid_t [LANES-1:0]       exu_valid_o,
  output exu_uop_t [LANES-1:0]         exu_uop_o,
  output logic [LANES-1:0]             exception_generated_o,
  output logic [LANES-1:0][4:0]        exception_vector_o,
  output decode_state_e                state_o
);

  decode_state_e               state_q;
  lane_pkt_t [LANES-1:0]       out_q;
  lane_pkt_t [LANES-1:0]       next_pkt;
  logic [CNT_W-1:0]            cnt;
  logic                        found;
  logic                        trunc_exc;
  logic                        trunc_fence;
  logic                        out_any;
  logic                        accept;

  // Decode every lane and keep lanes up to and including the first one that
  // must end the group (exception, fence or branch).
  always_comb begin
    next_pkt    = '0;
    cnt         = '0;
    found       = 1'b0;
    trunc_exc   = 1'b0;
    trunc_fence = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      lane_pkt_t d;
      d = integer_decoder(instr_i[l], instr_address_i[l], compressed_i[l], priv_level_i);
      if (valid_i[l] && !found) begin
        next_pkt[l] = d;
        cnt = cnt + CNT_W'(1);
        if (d.exc || d.fence || d.branch) begin
          found       = 1'b1;
          trunc_exc   = d.exc;
          trunc_fence = d.fence;
        end
      end
    end
  end

  assign out_any    = |valid_o;
  assign ready_o    = (state_q == RUN) && !flush_i && (!stall_i || !out_any);
  assign accept     = ready_o && valid_i[0];
  assign consumed_o = accept ? cnt : '0;
  assign state_o    = state_q;

  for (genvar g = 0; g < LANES; g++) begin : g_out
    assign valid_o[g]               = out_q[g].valid;
    assign instr_address_o[g]       = out_q[g].addr;
    assign compressed_o[g]          = out_q[g].compressed;
    assign immediate_o[g]           = out_q[g].imm;
    assign imm_valid_o[g]           = out_q[g].imm_valid;
    assign reg_src_o[g]             = out_q[g].src;
    assign reg_dest_o[g]            = out_q[g].dest;
    assign branch_o[g]              = out_q[g].branch;
    assign link_o[g]                = out_q[g].link;
    assign memory_o[g]              = out_q[g].memory;
    assign fence_o[g]               = out_q[g].fence;
    assign address_operand_o[g]     = out_q[g].addr_op;
    assign exu_valid_o[g]           = out_q[g].exu_valid;
    assign exu_uop_o[g]             = out_q[g].exu_uop;
    assign exception_generated_o[g] = out_q[g].exc;
    assign exception_vector_o[g]    = out_q[g].exc_vec;
  end

  // Output register and serialisation FSM; flush beats stall, waits and accepts.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RUN;
      out_q   <= '0;
    end else if (flush_i) begin
      state_q <= RUN;
      out_q   <= '0;
    end else begin
      if (accept) begin
        out_q <= next_pkt;
        if (trunc_exc) state_q <= EXC_HOLD;
        else if (trunc_fence) state_q <= FENCE_WAIT;
      end else if (!stall_i || !out_any) begin
        out_q <= '0;
      end
      if (state_q == FENCE_WAIT && pipeline_empty_i && !out_any && !stall_i) state_q <= RUN;
    end
  end

endmodule

// File: tb/tb_multi_issue_decode_stage.sv
// Directed bench for multi_issue_decode_stage with LANES=2.
module tb_multi_issue_decode_stage;
  import mids_pkg::*;

  localparam logic [31:0] I_ADDI  = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] I_ADD   = 32'h0010_8133;  // add  x2,x1,x1
  localparam logic [31:0] I_FENCE = 32'h0FF0_000F;  // fence iorw,iorw
  localparam logic [31:0] I_JAL   = 32'h0080_00EF;  // jal  x1,+8
  localparam logic [31:0] I_ILL   = 32'h0000_0000;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           valid_i;
  logic [1:0][31:0]     instr_i;
  logic [1:0][31:0]     instr_address_i;
  logic [1:0]           compressed_i;
  logic                 priv_level_i;
  logic                 stall_i;
  logic                 flush_i;
  logic                 pipeline_empty_i;
  logic                 ready_o;
  logic [1:0]           consumed_o;
  logic [1:0]           valid_o;
  logic [1:0][31:0]     instr_address_o;
  logic [1:0]           compressed_o;
  logic [1:0][1:0][31:0] immediate_o;
  logic [1:0][1:0]      imm_valid_o;
  logic [1:0][1:0][4:0] reg_src_o;
  logic [1:0][4:0]      reg_dest_o;
  logic [1:0]           branch_o, link_o, memory_o, fence_o;
  logic [1:0][1:0]      address_operand_o;
  exu_valid_t [1:0]     exu_valid_o;
  exu_uop_t [1:0]       exu_uop_o;
  logic [1:0]           exception_generated_o;
  logic [1:0][4:0]      exception_vector_o;
  decode_state_e        state_o;

  int tests = 0;
  int failed = 0;

  multi_issue_decode_stage #(.LANES(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .instr_i(instr_i),
    .instr_address_i(instr_address_i), .compressed_i(compressed_i),
    .priv_level_i(priv_level_i), .stall_i(stall_i), .flush_i(flush_i),
    .pipeline_empty_i(pipeline_empty_i), .ready_o(ready_o), .consumed_o(consumed_o),
    .valid_o(valid_o), .instr_address_o(instr_address_o), .compressed_o(compressed_o),
    .immediate_o(immediate_o), .imm_valid_o(imm_valid_o), .reg_src_o(reg_src_o),
    .reg_dest_o(reg_dest_o), .branch_o(branch_o), .link_o(link_o), .memory_o(memory_o),
    .fence_o(fence_o), .address_operand_o(address_operand_o), .exu_valid_o(exu_valid_o),
    .exu_uop_o(exu_uop_o), .exception_generated_o(exception_generated_o),
    .exception_vector_o(exception_vector_o), .state_o(state_o)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lane(input int l, input logic [31:0] ins, input logic [31:0] pc);
    instr_i[l] = ins;
    instr_address_i[l] = pc;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    valid_i = 2'b00;
    compressed_i = 2'b00;
    priv_level_i = 1'b1;
    stall_i = 1'b0;
    flush_i = 1'b0;
    pipeline_empty_i = 1'b0;
    lane(0, I_ADD, 32'h0);
    lane(1, I_ADD, 32'h4);
    tick();
    tick();
    chk("rst_valid", valid_o, 2'b00);
    chk("rst_exc", exception_generated_o, 2'b00);
    chk("rst_consumed", consumed_o, 2'd0);
    chk("rst_state", state_o, RUN);
    rst_n = 1'b1;
    tick();

    // Two plain ALU ops: full group accepted
    lane(0, I_ADDI, 32'h100);
    lane(1, I_ADD, 32'h104);
    valid_i = 2'b11;
    #1;
    chk("t1_ready", ready_o, 1'b1);
    chk("t1_consumed", consumed_o, 2'd2);
    tick();
    valid_i = 2'b00;
    chk("t1_valid", valid_o, 2'b11);
    chk("t1_imm", immediate_o[0][0], 32'd5);
    chk("t1_immv", imm_valid_o[0], 2'b01);
    chk("t1_dest", reg_dest_o, {5'd2, 5'd1});
    chk("t1_src1", reg_src_o[1], {5'd1, 5'd1});
    chk("t1_alu0", exu_valid_o[0].alu, 1'b1);
    chk("t1_exc", exception_generated_o, 2'b00);
    tick();
    chk("t1_drain", valid_o, 2'b00);

    // Fence truncates the group and waits for an empty pipeline
    lane(0, I_FENCE, 32'h200);
    lane(1, I_ADD, 32'h204);
    valid_i = 2'b11;
    #1;
    chk("t2_consumed", consumed_o, 2'd1);
    tick();
    lane(0, I_ADD, 32'h204);
    valid_i = 2'b01;
    chk("t2_valid", valid_o, 2'b01);
    chk("t2_fence", fence_o, 2'b01);
    chk("t2_state", state_o, FENCE_WAIT);
    chk("t2_ready0", ready_o, 1'b0);
    chk("t2_noconsume", consumed_o, 2'd0);
    tick();
    tick();
    chk("t2_wait_state", state_o, FENCE_WAIT);
    chk("t2_wait_ready", ready_o, 1'b0);
    pipeline_empty_i = 1'b1;
    #1;
    chk("t2_empty_ready", ready_o, 1'b0);
    tick();
    chk("t2_run", state_o, RUN);
    chk("t2_ready1", ready_o, 1'b1);
    chk("t2_consumed2", consumed_o, 2'd1);
    tick();
    valid_i = 2'b00;
    chk("t2_relaunch_valid", valid_o, 2'b01);
    chk("t2_relaunch_dest", reg_dest_o[0], 5'd2);
    chk("t2_relaunch_fence", fence_o, 2'b00);

    // JAL truncates but the FSM stays in RUN
    lane(0, I_JAL, 32'h300);
    lane(1, I_ADD, 32'h304);
    valid_i = 2'b11;
    #1;
    chk("t3_consumed", consumed_o, 2'd1);
    tick();
    valid_i = 2'b00;
    chk("t3_valid", valid_o, 2'b01);
    chk("t3_branch", branch_o, 2'b01);
    chk("t3_link", link_o, 2'b01);
    chk("t3_imm0", immediate_o[0][0], 32'd8);
    chk("t3_ret", immediate_o[0][1], 32'h304);
    chk("t3_state", state_o, RUN);
    chk("t3_ready", ready_o, 1'b1);

    // Illegal instruction in lane 1 parks the FSM until flush
    lane(0, I_ADD, 32'h400);
    lane(1, I_ILL, 32'h404);
    valid_i = 2'b11;
    #1;
    chk("t4_consumed", consumed_o, 2'd2);
    tick();
    valid_i = 2'b00;
    chk("t4_valid", valid_o, 2'b11);
    chk("t4_exc", exception_generated_o, 2'b10);
    chk("t4_vec", exception_vector_o[1], 5'd2);
    chk("t4_exu1", exu_valid_o[1], 4'h0);
    chk("t4_exu0_alu", exu_valid_o[0].alu, 1'b1);
    chk("t4_state", state_o, EXC_HOLD);
    chk("t4_ready", ready_o, 1'b0);
    tick();
    tick();
    chk("t4_hold_state", state_o, EXC_HOLD);
    chk("t4_hold_ready", ready_o, 1'b0);
    lane(0, I_ADD, 32'h500);
    valid_i = 2'b01;
    flush_i = 1'b1;
    #1;
    chk("t4_flush_ready", ready_o, 1'b0);
    chk("t4_flush_consumed", consumed_o, 2'd0);
    tick();
    flush_i = 1'b0;
    #1;
    chk("t4_post_valid", valid_o, 2'b00);
    chk("t4_post_state", state_o, RUN);
    chk("t4_post_ready", ready_o, 1'b1);
    chk("t4_post_consumed", consumed_o, 2'd1);

    // Stall holds a valid packet for three cycles
    tick();
    chk("t5_loaded", valid_o, 2'b01);
    stall_i = 1'b1;
    lane(0, I_ADDI, 32'h600);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_stall_ready", ready_o, 1'b0);
      chk("t5_stall_consumed", consumed_o, 2'd0);
      tick();
      chk("t5_hold_valid", valid_o, 2'b01);
      chk("t5_hold_pc", instr_address_o[0], 32'h500);
      chk("t5_hold_dest", reg_dest_o[0], 5'd2);
    end
    stall_i = 1'b0;
    #1;
    chk("t5_release_ready", ready_o, 1'b1);
    chk("t5_release_consumed", consumed_o, 2'd1);
    tick();
    valid_i = 2'b00;
    chk("t5_new_pc", instr_address_o[0], 32'h600);
    chk("t5_new_imm", immediate_o[0][0], 32'd5);
    tick();

    // Flush while stalled in FENCE_WAIT
    pipeline_empty_i = 1'b0;
    lane(0, I_FENCE, 32'h700);
    valid_i = 2'b01;
    tick();
    valid_i = 2'b00;
    stall_i = 1'b1;
    chk("t6_state", state_o, FENCE_WAIT);
    chk("t6_valid", valid_o, 2'b01);
    tick();
    chk("t6_held", valid_o, 2'b01);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    chk("t6_flush_valid", valid_o, 2'b00);
    chk("t6_flush_state", state_o, RUN);
    chk("t6_bubble_ready", ready_o, 1'b1);

    // Asynchronous reset while stalled with a valid packet
    lane(0, I_ADDI, 32'h800);
    valid_i = 2'b01;
    tick();
    valid_i = 2'b00;
    chk("t7_loaded", valid_o, 2'b01);
    tick();
    chk("t7_held", valid_o, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_async_valid", valid_o, 2'b00);
    chk("t7_async_state", state_o, RUN);
    chk("t7_async_consumed", consumed_o, 2'd0);
    stall_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t7_ready", ready_o, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
